// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : 2-wide circular instruction queue between fetch and decode with
//            branch wrong-path lane squash, back-pressure and single-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  in_valid,
    input  logic [ADDR_WIDTH-1:0]       in_pc0,
    input  logic [ADDR_WIDTH-1:0]       in_pc1,
    input  logic [31:0]                 in_instr0,
    input  logic [31:0]                 in_instr1,
    input  logic [1:0]                  in_guesses_branch,
    input  logic [ADDR_WIDTH-1:0]       in_prediction0,
    input  logic [ADDR_WIDTH-1:0]       in_prediction1,
    input  logic                        flush,
    input  logic                        dec_stall,
    output logic                        fetch_stall,
    output logic [1:0]                  out_valid,
    output logic [ADDR_WIDTH-1:0]       out_pc0,
    output logic [ADDR_WIDTH-1:0]       out_pc1,
    output logic [31:0]                 out_instr0,
    output logic [31:0]                 out_instr1,
    output logic [1:0]                  out_guesses_branch,
    output logic [ADDR_WIDTH-1:0]       out_prediction0,
    output logic [ADDR_WIDTH-1:0]       out_prediction1,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] C_NEAR_FULL = CW'(DEPTH - 1);
    localparam logic [CW-1:0] C_TWO       = CW'(2);
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [PW-1:0] C_PTR_ONE   = PW'(1);

    // Storage
    logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
    logic [31:0]           r_instr[DEPTH];
    logic                  r_gb   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pred [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [PW-1:0] w_head1;
    logic [PW-1:0] w_tail1;
    logic          w_accept;
    logic          w_eff0;
    logic          w_eff1;
    logic [CW-1:0] w_enq;
    logic [CW-1:0] w_deq;

    logic                  w_wr_a_en;
    logic                  w_wr_b_en;
    logic [ADDR_WIDTH-1:0] w_wr_a_pc;
    logic [31:0]           w_wr_a_instr;
    logic                  w_wr_a_gb;
    logic [ADDR_WIDTH-1:0] w_wr_a_pred;

    assign w_head1 = r_head + C_PTR_ONE;
    assign w_tail1 = r_tail + C_PTR_ONE;

    // Stall looks only at registered occupancy so fetch never sees a comb path.
    assign fetch_stall  = (r_count >= C_NEAR_FULL);
    assign out_valid[0] = (r_count >= C_ONE);
    assign out_valid[1] = (r_count >= C_TWO);
    assign count        = r_count;

    assign out_pc0               = r_pc[r_head];
    assign out_pc1               = r_pc[w_head1];
    assign out_instr0            = r_instr[r_head];
    assign out_instr1            = r_instr[w_head1];
    assign out_guesses_branch[0] = r_gb[r_head];
    assign out_guesses_branch[1] = r_gb[w_head1];
    assign out_prediction0       = r_pred[r_head];
    assign out_prediction1       = r_pred[w_head1];

    always_comb begin
        w_deq = '0;
        if (!dec_stall) begin
            if (out_valid[1]) begin
                w_deq = C_TWO;
            end else if (out_valid[0]) begin
                w_deq = C_ONE;
            end
        end
    end

    // Lane1 is wrong-path when lane0 is a predicted-taken branch.
    assign w_accept = ~fetch_stall & ~flush;
    assign w_eff0   = w_accept & in_valid[0];
    assign w_eff1   = w_accept & in_valid[1] & ~(in_valid[0] & in_guesses_branch[0]);
    assign w_enq    = {{(CW-1){1'b0}}, w_eff0} + {{(CW-1){1'b0}}, w_eff1};

    // Compaction: the first effective lane always lands at tail.
    always_comb begin
        w_wr_a_en    = w_eff0 | w_eff1;
        w_wr_b_en    = w_eff0 & w_eff1;
        w_wr_a_pc    = in_pc1;
        w_wr_a_instr = in_instr1;
        w_wr_a_gb    = in_guesses_branch[1];
        w_wr_a_pred  = in_prediction1;
        if (w_eff0) begin
            w_wr_a_pc    = in_pc0;
            w_wr_a_instr = in_instr0;
            w_wr_a_gb    = in_guesses_branch[0];
            w_wr_a_pred  = in_prediction0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_a_en) begin
            r_pc[r_tail]    <= w_wr_a_pc;
            r_instr[r_tail] <= w_wr_a_instr;
            r_gb[r_tail]    <= w_wr_a_gb;
            r_pred[r_tail]  <= w_wr_a_pred;
        end
        if (w_wr_b_en) begin
            r_pc[w_tail1]    <= in_pc1;
            r_instr[w_tail1] <= in_instr1;
            r_gb[w_tail1]    <= in_guesses_branch[1];
            r_pred[w_tail1]  <= in_prediction1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq[PW-1:0];
            r_tail  <= r_tail + w_enq[PW-1:0];
            r_count <= r_count + w_enq - w_deq;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Self-checking bench for fetch_buffer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     in_valid;
    logic [AW-1:0]  in_pc0, in_pc1;
    logic [31:0]    in_instr0, in_instr1;
    logic [1:0]     in_guesses_branch;
    logic [AW-1:0]  in_prediction0, in_prediction1;
    logic           flush;
    logic           dec_stall;
    logic           fetch_stall;
    logic [1:0]     out_valid;
    logic [AW-1:0]  out_pc0, out_pc1;
    logic [31:0]    out_instr0, out_instr1;
    logic [1:0]     out_guesses_branch;
    logic [AW-1:0]  out_prediction0, out_prediction1;
    logic [CW-1:0]  count;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        logic          gb;
        logic [AW-1:0] pred;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_pc0             (in_pc0),
        .in_pc1             (in_pc1),
        .in_instr0          (in_instr0),
        .in_instr1          (in_instr1),
        .in_guesses_branch  (in_guesses_branch),
        .in_prediction0     (in_prediction0),
        .in_prediction1     (in_prediction1),
        .flush              (flush),
        .dec_stall          (dec_stall),
        .fetch_stall        (fetch_stall),
        .out_valid          (out_valid),
        .out_pc0            (out_pc0),
        .out_pc1            (out_pc1),
        .out_instr0         (out_instr0),
        .out_instr1         (out_instr1),
        .out_guesses_branch (out_guesses_branch),
        .out_prediction0    (out_prediction0),
        .out_prediction1    (out_prediction1),
        .count              (count)
    );

    always #5 clk = ~clk;

    // One clock of the reference queue: flush clears, else pop then push.
    task automatic tick();
        bit   stall;
        int   deq;
        ent_t e0, e1;
        stall = (q.size() >= DEPTH - 1);
        e0 = '{pc: in_pc0, instr: in_instr0, gb: in_guesses_branch[0], pred: in_prediction0};
        e1 = '{pc: in_pc1, instr: in_instr1, gb: in_guesses_branch[1], pred: in_prediction1};
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            deq = dec_stall ? 0 : ((q.size() >= 2) ? 2 : q.size());
            for (int i = 0; i < deq; i++) q.delete(0);
            if (!stall) begin
                if (in_valid[0]) q.push_back(e0);
                if (in_valid[1] && !(in_valid[0] && in_guesses_branch[0])) q.push_back(e1);
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                         input logic [1:0] gb);
        in_valid          = v;
        in_pc0            = p0;
        in_pc1            = p1;
        in_guesses_branch = gb;
        in_instr0         = $urandom;
        in_instr1         = $urandom;
        in_prediction0    = $urandom;
        in_prediction1    = $urandom;
    endtask

    task automatic idle();
        in_valid = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic clear();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        dec_stall = 1'b0;
        drive(2'b00, '0, '0, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_fetch_stall got %b exp 0", fetch_stall); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    endtask

    task automatic test_basic();
        dec_stall = 1'b0;
        drive(2'b11, 32'h100, 32'h104, 2'b00);
        tick();
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b exp 11", out_valid); end
        checks++; if (out_pc0 !== 32'h100 || out_pc1 !== 32'h104)
            begin errors++; $display("FAIL basic_pcs got %h/%h exp 100/104", out_pc0, out_pc1); end
        idle();
        tick();
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL basic_drain got %b exp 00", out_valid); end
    endtask

    task automatic test_branch();
        dec_stall = 1'b0;
        drive(2'b11, 32'h200, 32'h204, 2'b01);
        tick();
        checks++; if (count !== 1) begin errors++; $display("FAIL squash_count got %0d exp 1", count); end
        checks++; if (out_pc0 !== 32'h200) begin errors++; $display("FAIL squash_pc got %h exp 200", out_pc0); end
        drive(2'b10, 32'h0, 32'h308, 2'b00);
        tick();
        checks++; if (count !== 1 || out_pc0 !== 32'h308)
            begin errors++; $display("FAIL compact got count %0d pc %h exp 1 308", count, out_pc0); end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        dec_stall = 1'b1;
        drive(2'b11, 32'h10, 32'h14, 2'b00); tick();
        drive(2'b11, 32'h18, 32'h1C, 2'b00); tick();
        drive(2'b01, 32'h20, 32'h24, 2'b00); tick();
        idle();
        checks++; if (count !== 5) begin errors++; $display("FAIL areset_pre got %0d exp 5", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 0 || out_valid !== 2'b00)
            begin errors++; $display("FAIL areset_clear got count %0d valid %b exp 0 00", count, out_valid); end
        q.delete();
        #1 reset = 1'b0;
        dec_stall = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        clear();
        dec_stall = 1'b1;
        for (int g = 0; g < 4; g++) begin
            drive(2'b11, 32'h400 + 8 * g, 32'h404 + 8 * g, 2'b00);
            tick();
        end
        checks++; if (count !== 8 || fetch_stall !== 1'b1)
            begin errors++; $display("FAIL bp_full got count %0d stall %b exp 8 1", count, fetch_stall); end
        drive(2'b11, 32'h420, 32'h424, 2'b00);
        tick();
        checks++; if (count !== 8) begin errors++; $display("FAIL bp_held got %0d exp 8", count); end
        dec_stall = 1'b0;
        tick();
        dec_stall = 1'b1;
        checks++; if (count !== 6 || fetch_stall !== 1'b0)
            begin errors++; $display("FAIL bp_release got count %0d stall %b exp 6 0", count, fetch_stall); end
        checks++; if (out_pc0 !== 32'h408 || out_pc1 !== 32'h40C)
            begin errors++; $display("FAIL bp_order got %h/%h exp 408/40c", out_pc0, out_pc1); end
        clear();
    endtask

    task automatic test_wrap();
        int nin = 0, nout = 0, cyc = 0, n;
        clear();
        while (nout < 20 && cyc < 400) begin
            dec_stall = cyc[0];
            checks++;
            if (out_valid !== {q.size() >= 2, q.size() >= 1})
                begin errors++; $display("FAIL wrap_valid got %b exp size %0d", out_valid, q.size()); end
            if (!dec_stall) begin
                n = (q.size() >= 2) ? 2 : q.size();
                for (int l = 0; l < n; l++) begin
                    checks++;
                    if (((l == 0) ? out_pc0 : out_pc1) !== AW'(nout * 4)) begin
                        errors++;
                        $display("FAIL wrap_pc lane %0d got %h exp %h", l, (l == 0) ? out_pc0 : out_pc1, nout * 4);
                    end
                    nout++;
                end
            end
            n = 0;
            if (!(q.size() >= DEPTH - 1) && nin < 20) n = (nin <= 18) ? 2 : 1;
            if (n == 2) drive(2'b11, AW'(nin * 4), AW'(nin * 4 + 4), 2'b00);
            else if (n == 1) drive(2'b01, AW'(nin * 4), '0, 2'b00);
            else idle();
            tick();
            nin += n;
            cyc++;
        end
        checks++; if (nout != 20) begin errors++; $display("FAIL wrap_timeout got %0d exp 20", nout); end
        idle();
        checks++; if (count !== 0) begin errors++; $display("FAIL wrap_leftover got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        clear();
        dec_stall = 1'b1;
        for (int g = 0; g < 3; g++) begin
            drive(2'b11, 32'h500 + 8 * g, 32'h504 + 8 * g, 2'b00);
            tick();
        end
        checks++; if (count !== 6) begin errors++; $display("FAIL flush_pre got %0d exp 6", count); end
        drive(2'b11, 32'h580, 32'h584, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 0 || out_valid !== 2'b00)
            begin errors++; $display("FAIL flush_clear got count %0d valid %b exp 0 00", count, out_valid); end
        dec_stall = 1'b0;
        drive(2'b11, 32'h600, 32'h604, 2'b00);
        tick();
        idle();
        checks++; if (out_valid !== 2'b11 || out_pc0 !== 32'h600 || out_pc1 !== 32'h604)
            begin errors++; $display("FAIL flush_after got %b %h/%h exp 11 600/604", out_valid, out_pc0, out_pc1); end
        tick();
    endtask

    task automatic test_random();
        ent_t e;
        clear();
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (count !== CW'(q.size()) || fetch_stall !== (q.size() >= DEPTH - 1) ||
                out_valid !== {q.size() >= 2, q.size() >= 1}) begin
                errors++;
                $display("FAIL rand_state cyc %0d got count %0d stall %b valid %b exp size %0d",
                         c, count, fetch_stall, out_valid, q.size());
            end
            if (q.size() >= 1) begin
                e = q[0];
                checks++;
                if ({out_pc0, out_instr0, out_guesses_branch[0], out_prediction0} !== {e.pc, e.instr, e.gb, e.pred}) begin
                    errors++;
                    $display("FAIL rand_lane0 cyc %0d got %h %h %b %h exp %h %h %b %h", c, out_pc0, out_instr0,
                             out_guesses_branch[0], out_prediction0, e.pc, e.instr, e.gb, e.pred);
                end
            end
            if (q.size() >= 2) begin
                e = q[1];
                checks++;
                if ({out_pc1, out_instr1, out_guesses_branch[1], out_prediction1} !== {e.pc, e.instr, e.gb, e.pred}) begin
                    errors++;
                    $display("FAIL rand_lane1 cyc %0d got %h %h %b %h exp %h %h %b %h", c, out_pc1, out_instr1,
                             out_guesses_branch[1], out_prediction1, e.pc, e.instr, e.gb, e.pred);
                end
            end
            drive(2'($urandom), $urandom, $urandom, 2'($urandom));
            dec_stall = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_async_reset();
        test_backpressure();
        test_wrap();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
